// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the pwm block family: default compare width and
// the ramp controller state encoding.
package pwm_pkg;

    // Default compare/counter width, shared with the downstream pwm generator.
    localparam int PWM_CTR_LEN = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } ramp_state_e;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Target-duty handshake between the command path (master) and the duty
// ramp controller (slave).
interface pwm_duty_ramp_if
    import pwm_pkg::*;
#(
    parameter int CTR_LEN = PWM_CTR_LEN,
    parameter int DIV_LEN = 8
);
    logic               tgt_valid;
    logic               tgt_ready;
    logic [CTR_LEN-1:0] tgt_duty;
    logic [DIV_LEN-1:0] step_div;

    modport master (output tgt_valid, tgt_duty, step_div, input tgt_ready);
    modport slave  (input tgt_valid, tgt_duty, step_div, output tgt_ready);
endinterface

// File: rtl/pwm_duty_ramp_tick_div.sv
// Prescaler for the duty ramp: counts period ticks and strobes once every
// 'div' ticks. 'div' is never 0 here (the top substitutes 1 for 0).
module pwm_tick_div #(
    parameter int DIV_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               tick,
    input  logic [DIV_LEN-1:0] div,
    output logic               step_strobe
);
    logic [DIV_LEN-1:0] cnt;
    logic [DIV_LEN:0]   cnt_inc;

    assign cnt_inc     = {1'b0, cnt} + {{DIV_LEN{1'b0}}, 1'b1};
    assign step_strobe = tick && (cnt_inc == {1'b0, div});

    // Count ticks; restart on clear or when a step is strobed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (clear)       cnt <= '0;
        else if (step_strobe) cnt <= '0;
        else if (tick)        cnt <= cnt_inc[DIV_LEN-1:0];
    end
endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty ramp for the pwm generator: accepts a target duty and slews cmp_reg
// toward it by STEP every step_div period ticks, only on period boundaries.
// Optional macro PWM_RAMP_RETARGET_EN: accept new targets while ramping.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int CTR_LEN = PWM_CTR_LEN,
    parameter int STEP    = 1,
    parameter int DIV_LEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               period_tick,
    input  logic               stop,
    pwm_duty_ramp_if.slave     tgt,
    output logic [CTR_LEN-1:0] cmp_reg,
    output logic               busy,
    output logic               at_target
);
    localparam logic [CTR_LEN:0]   STEP_W = (CTR_LEN+1)'(STEP);
    localparam logic [CTR_LEN-1:0] STEP_C = CTR_LEN'(STEP);

    ramp_state_e        state, state_nxt;
    logic [CTR_LEN-1:0] target_q, target_nxt, cmp_nxt, cmp_step;
    logic [DIV_LEN-1:0] div_q, div_nxt;
    logic [CTR_LEN:0]   diff, mag;
    logic               accept, step_strobe, step, ramp_tick;

    assign accept    = tgt.tgt_valid && tgt.tgt_ready;
    assign ramp_tick = period_tick && (state == ST_RAMP);
    // A retarget or stop on the same edge wins over a pending step.
    assign step      = step_strobe && !accept && !stop;

    pwm_tick_div #(.DIV_LEN(DIV_LEN)) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (stop || accept),
        .tick        (ramp_tick),
        .div         (div_q),
        .step_strobe (step_strobe)
    );

    // One slew step toward target; widened difference keeps it wrap-free.
    always_comb begin
        diff = {1'b0, target_q} - {1'b0, cmp_reg};
        mag  = diff[CTR_LEN] ? ({(CTR_LEN+1){1'b0}} - diff) : diff;
        if (mag <= STEP_W)      cmp_step = target_q;
        else if (diff[CTR_LEN]) cmp_step = cmp_reg - STEP_C;
        else                    cmp_step = cmp_reg + STEP_C;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: stop, then new target, then arrival at target.
    always_comb begin
        state_nxt = state;
        if (stop)
            state_nxt = ST_IDLE;
        else if (accept)
            state_nxt = (tgt.tgt_duty != cmp_reg) ? ST_RAMP : ST_IDLE;
        else if (step && (cmp_step == target_q))
            state_nxt = ST_IDLE;
    end

    // Handshake and status outputs from the current state.
    always_comb begin
        busy = (state == ST_RAMP);
`ifdef PWM_RAMP_RETARGET_EN
        tgt.tgt_ready = !stop;
`else
        tgt.tgt_ready = !stop && (state == ST_IDLE);
`endif
    end

    // Next datapath values; stop is an immediate, non-period-aligned cut.
    always_comb begin
        cmp_nxt    = cmp_reg;
        target_nxt = target_q;
        div_nxt    = div_q;
        if (stop) begin
            cmp_nxt    = '0;
            target_nxt = '0;
        end else if (accept) begin
            target_nxt = tgt.tgt_duty;
            div_nxt    = (tgt.step_div == '0) ? DIV_LEN'(1) : tgt.step_div;
        end else if (step) begin
            cmp_nxt    = cmp_step;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_reg   <= '0;
            target_q  <= '0;
            div_q     <= DIV_LEN'(1);
            at_target <= 1'b1;
        end else begin
            cmp_reg   <= cmp_nxt;
            target_q  <= target_nxt;
            div_q     <= div_nxt;
            at_target <= (cmp_nxt == target_nxt);
        end
    end
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed scenarios plus random
// stimulus, all compared against a cycle-level behavioural model.
module tb_pwm_duty_ramp;
    localparam int CL   = 8;
    localparam int DL   = 8;
    localparam int STEP = 4;
`ifdef PWM_RAMP_RETARGET_EN
    localparam bit RETGT = 1'b1;
`else
    localparam bit RETGT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          period_tick = 1'b0;
    logic          stop = 1'b0;
    logic [CL-1:0] cmp_reg;
    logic          busy, at_target;

    pwm_duty_ramp_if #(.CTR_LEN(CL), .DIV_LEN(DL)) tif ();

    pwm_duty_ramp #(.CTR_LEN(CL), .STEP(STEP), .DIV_LEN(DL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .period_tick (period_tick),
        .stop        (stop),
        .tgt         (tif),
        .cmp_reg     (cmp_reg),
        .busy        (busy),
        .at_target   (at_target)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Model of the controller: current duty, target, ticks since last step.
    int m_cmp, m_tgt, m_pre, m_div;
    bit m_ramp;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cmp = 0; m_tgt = 0; m_pre = 0; m_div = 1; m_ramp = 0;
    endtask

    // One clock cycle: drive, check ready, advance model, check outputs.
    task automatic cyc(input bit tk, input bit vld, input int duty, input int div, input bit stp);
        bit rdy, acc;
        int d;
        @(negedge clk);
        period_tick   = tk;
        tif.tgt_valid = vld;
        tif.tgt_duty  = duty[CL-1:0];
        tif.step_div  = div[DL-1:0];
        stop          = stp;
        #1;
        rdy = !stp && (!m_ramp || RETGT);
        chk("tgt_ready", int'(tif.tgt_ready), int'(rdy));
        acc = vld && rdy;
        if (stp) begin
            m_cmp = 0; m_tgt = 0; m_pre = 0; m_ramp = 0;
        end else if (acc) begin
            m_tgt  = duty % 256;
            m_div  = (div % 256 == 0) ? 1 : div % 256;
            m_pre  = 0;
            m_ramp = (m_tgt != m_cmp);
        end else if (m_ramp && tk) begin
            m_pre++;
            if (m_pre >= m_div) begin
                m_pre = 0;
                d = m_tgt - m_cmp;
                if (d <= STEP && d >= -STEP) m_cmp = m_tgt;
                else if (d > 0)              m_cmp = m_cmp + STEP;
                else                         m_cmp = m_cmp - STEP;
                if (m_cmp == m_tgt) m_ramp = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("cmp_reg", int'(cmp_reg), m_cmp);
        chk("busy", int'(busy), int'(m_ramp));
        chk("at_target", int'(at_target), int'(m_cmp == m_tgt));
    endtask

    // n pwm periods of len cycles, tick on the last cycle of each.
    task automatic periods(input int n, input int len);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < len - 1; c++) cyc(0, 0, 0, 0, 0);
            cyc(1, 0, 0, 0, 0);
        end
    endtask

    // Tick every cycle until the model settles, bounded.
    task automatic settle(input string tag);
        for (int i = 0; i < 300 && m_ramp; i++) cyc(1, 0, 0, 0, 0);
        chk(tag, int'(busy), 0);
    endtask

    int up_exp[3]   = '{4, 8, 10};
    int down_exp[3] = '{6, 2, 0};

    initial begin
        tif.tgt_valid = 1'b0;
        tif.tgt_duty  = '0;
        tif.step_div  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_cmp", int'(cmp_reg), 0);
        chk("rst_ready", int'(tif.tgt_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);

        // Ramp up to 10, one step per 8-cycle period.
        cyc(0, 1, 10, 1, 0);
        chk("up_busy", int'(busy), 1);
        for (int p = 0; p < 3; p++) begin
            periods(1, 8);
            chk("up_step", int'(cmp_reg), up_exp[p]);
        end
        chk("up_done_busy", int'(busy), 0);
        chk("up_done_ready", int'(tif.tgt_ready), 1);

        // Ramp down to 0, a step every third period.
        cyc(0, 1, 0, 3, 0);
        for (int p = 1; p <= 9; p++) begin
            periods(1, 4);
            if (p % 3 == 0) chk("down_step", int'(cmp_reg), down_exp[p/3 - 1]);
        end

        // Top boundary: 253 -> 255 with STEP 4 must clamp.
        cyc(0, 1, 253, 1, 0);
        settle("to253_settle");
        chk("to253", int'(cmp_reg), 253);
        cyc(0, 1, 255, 1, 0);
        cyc(1, 0, 0, 0, 0);
        chk("top_clamp", int'(cmp_reg), 255);

        // step_div 0 acts as 1.
        cyc(0, 1, 251, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("div0", int'(cmp_reg), 251);

        // Target equal to current duty: never busy.
        cyc(0, 1, 251, 2, 0);
        chk("eq_busy", int'(busy), 0);
        periods(3, 2);
        chk("eq_busy_later", int'(busy), 0);

        // Stop from 251, then stop mid-ramp at 8 with a concurrent request.
        cyc(0, 0, 0, 0, 1);
        chk("stop_cmp", int'(cmp_reg), 0);
        cyc(0, 1, 20, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("pre_stop_cmp", int'(cmp_reg), 8);
        cyc(1, 1, 100, 1, 1);
        chk("stop_mid_cmp", int'(cmp_reg), 0);
        chk("stop_mid_at", int'(at_target), 1);
        cyc(1, 0, 0, 0, 0);
        chk("stop_dropped", int'(busy), 0);

        // Retarget attempt during a ramp to 200.
        cyc(0, 1, 200, 1, 0);
        periods(5, 1);
        cyc(0, 1, 50, 2, 0);
        cyc(1, 1, 50, 2, 0);
        cyc(0, 0, 0, 0, 0);
        settle("retgt_settle");
        chk("retgt_final", int'(cmp_reg), RETGT ? 50 : 200);

        // Random traffic.
        for (int i = 0; i < 800; i++)
            cyc($urandom % 3 == 0, $urandom % 4 == 0, int'($urandom % 256),
                int'($urandom % 4), $urandom % 60 == 0);

        // Asynchronous reset in the middle of a ramp.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 240, 1, 0);
        periods(3, 1);
        @(negedge clk);
        period_tick = 1'b0; tif.tgt_valid = 1'b0; stop = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_cmp", int'(cmp_reg), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_at_target", int'(at_target), 1);
        chk("arst_ready", int'(tif.tgt_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        periods(2, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
